// File: rtl/planar_rgb_serializer_if.sv
// Pixel-in / planar-byte-out bundle for planar_rgb_serializer.
//   pix_valid, pix_sof, pix_rgb : interleaved raster pixels from upstream
//   pix_ready                   : serializer can take a pixel this cycle
//   byte_out, byte_valid        : planar byte stream (all R, then all G, then all B)
//   frame_start, frame_done     : one-cycle markers on the first and last byte of a frame
//   frame_err                   : sticky framing error (start-of-frame mid frame)
// Modport master is the pixel source / byte sink; modport slave is the serializer.
interface planar_rgb_serializer_if;
    logic        pix_valid;
    logic        pix_sof;
    logic [23:0] pix_rgb;
    logic        pix_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        frame_start;
    logic        frame_done;
    logic        frame_err;

    modport master (
        output pix_valid,
        output pix_sof,
        output pix_rgb,
        input  pix_ready,
        input  byte_out,
        input  byte_valid,
        input  frame_start,
        input  frame_done,
        input  frame_err
    );

    modport slave (
        input  pix_valid,
        input  pix_sof,
        input  pix_rgb,
        output pix_ready,
        output byte_out,
        output byte_valid,
        output frame_start,
        output frame_done,
        output frame_err
    );
endinterface

// File: rtl/planar_rgb_serializer.sv
// Buffers one frame of interleaved RGB pixels into three colour planes, then replays it as
// a planar byte stream: N red bytes, N green bytes, N blue bytes, back to back.
// Ports:
//   clk_i  : single clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : planar_rgb_serializer_if.slave (pixel input handshake, byte stream output)
// Parameters:
//   RES_X, RES_Y : frame size in pixels; N = RES_X * RES_Y
module planar_rgb_serializer #(
    parameter int unsigned RES_X = 32,
    parameter int unsigned RES_Y = 32
) (
    input  logic                     clk_i,
    input  logic                     reset,
    planar_rgb_serializer_if.slave   bus
);
    localparam int unsigned N     = RES_X * RES_Y;
    localparam int unsigned AddrW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IdxW  = $clog2(N) + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [1:0] {StFill, StDrainR, StDrainG, StDrainB} state_e;

    state_e state_q, state_d;

    logic [7:0] r_plane [N];
    logic [7:0] g_plane [N];
    logic [7:0] b_plane [N];

    logic [IdxW-1:0] wr_idx_q, wr_idx_d;
    logic [IdxW-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]      byte_q, byte_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_done_q, frame_done_d;
    logic            frame_err_q, frame_err_d;

    logic            pix_ready;
    logic            accept;
    logic [IdxW-1:0] wr_addr;
    logic            wr_last;
    logic            rd_last;
    logic [AddrW-1:0] rd_addr;

    // A start-of-frame pixel always lands at index 0, restarting any partial frame.
    always_comb begin
        accept  = bus.pix_valid && pix_ready;
        wr_addr = bus.pix_sof ? '0 : wr_idx_q;
        wr_last = (wr_addr == LastIdx);
        rd_last = (rd_idx_q == LastIdx);
        rd_addr = rd_idx_q[AddrW-1:0];
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:   if (accept && wr_last) state_d = StDrainR;
            StDrainR: if (rd_last) state_d = StDrainG;
            StDrainG: if (rd_last) state_d = StDrainB;
            StDrainB: if (rd_last) state_d = StFill;
            default:  state_d = StFill;
        endcase
    end

    // Output logic. Ready also waits for the last registered B byte to leave, so the
    // next frame cannot start filling until the stream has fully drained.
    always_comb begin
        pix_ready     = (state_q == StFill) && !byte_valid_q;
        byte_valid_d  = 1'b0;
        byte_d        = '0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        unique case (state_q)
            StFill: ;
            StDrainR: begin
                byte_valid_d  = 1'b1;
                byte_d        = r_plane[rd_addr];
                frame_start_d = (rd_idx_q == '0);
            end
            StDrainG: begin
                byte_valid_d = 1'b1;
                byte_d       = g_plane[rd_addr];
            end
            StDrainB: begin
                byte_valid_d = 1'b1;
                byte_d       = b_plane[rd_addr];
                frame_done_d = rd_last;
            end
            default: ;
        endcase
    end

    // Index and error next-state
    always_comb begin
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = '0;
        frame_err_d = frame_err_q;
        if (accept) begin
            wr_idx_d = wr_last ? '0 : wr_addr + IdxW'(1);
            if (bus.pix_sof && (wr_idx_q != '0)) begin
                frame_err_d = 1'b1;
            end
        end
        if (state_q != StFill) begin
            rd_idx_d = rd_last ? '0 : rd_idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            byte_q        <= '0;
            byte_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            byte_q        <= byte_d;
            byte_valid_q  <= byte_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Plane storage carries no reset; contents are only read after a complete fill.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            r_plane[wr_addr[AddrW-1:0]] <= bus.pix_rgb[23:16];
            g_plane[wr_addr[AddrW-1:0]] <= bus.pix_rgb[15:8];
            b_plane[wr_addr[AddrW-1:0]] <= bus.pix_rgb[7:0];
        end
    end

    assign bus.pix_ready   = pix_ready;
    assign bus.byte_out    = byte_q;
    assign bus.byte_valid  = byte_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_err   = frame_err_q;
endmodule

// File: tb/tb_planar_rgb_serializer.sv
// Self-checking bench for planar_rgb_serializer: a 4x4 instance for the functional and
// corner-case sequences, and a default 32x32 instance for back-to-back full-size frames.
module tb_planar_rgb_serializer;
    localparam int N4  = 16;
    localparam int N32 = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    planar_rgb_serializer_if bus4 ();
    planar_rgb_serializer_if bus32 ();

    planar_rgb_serializer #(.RES_X(4), .RES_Y(4)) dut4 (
        .clk_i (clk),
        .reset (reset),
        .bus   (bus4)
    );

    planar_rgb_serializer dut32 (
        .clk_i (clk),
        .reset (reset),
        .bus   (bus32)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        sof;
        logic [23:0] rgb;
        logic [7:0]  exp_r;
        logic [7:0]  exp_g;
        logic [7:0]  exp_b;
    } vec_t;
    vec_t vec [N4];

    // Reference model for the 4x4 instance: frame buffer plus expected byte stream.
    int          m_idx;
    logic [23:0] m_frame [N4];
    logic        m_err;
    logic [7:0]  exp_q [$];
    logic [23:0] px32 [N32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic sof, input logic [23:0] rgb);
        if (sof) begin
            if (m_idx != 0) m_err = 1'b1;
            m_idx = 0;
        end
        m_frame[m_idx] = rgb;
        m_idx++;
        if (m_idx == N4) begin
            for (int p = 0; p < 3; p++)
                for (int i = 0; i < N4; i++)
                    exp_q.push_back(8'(m_frame[i] >> (16 - 8 * p)));
            m_idx = 0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send4(input logic sof, input logic [23:0] rgb, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        for (int g = 0; g < gap; g++) begin
            bus4.pix_valid = 1'b0;
            bus4.pix_sof   = 1'($urandom);
            bus4.pix_rgb   = 24'($urandom);
            @(negedge clk);
        end
        check("fill_ready", 32'(bus4.pix_ready), 32'd1);
        bus4.pix_valid = 1'b1;
        bus4.pix_sof   = sof;
        bus4.pix_rgb   = rgb;
        @(posedge clk);
        model_accept(sof, rgb);
        @(negedge clk);
        bus4.pix_valid = 1'b0;
    endtask

    task automatic drive_noise4(input bit noise);
        bus4.pix_valid = noise;
        bus4.pix_sof   = 1'($urandom);
        bus4.pix_rgb   = 24'($urandom);
    endtask

    // Called at the negedge right after the edge that accepted the last pixel.
    task automatic drain4(input logic [7:0] exp[$], input bit noise, input string tag);
        int lat;
        int low;
        lat = 0;
        low = 0;
        while (!bus4.byte_valid && lat < 8) begin
            if (!bus4.pix_ready) low++;
            drive_noise4(noise);
            @(negedge clk);
            lat++;
        end
        check($sformatf("%s_first_valid_latency", tag), 32'(lat), 32'd1);
        if (!bus4.byte_valid) return;
        for (int k = 0; k < exp.size(); k++) begin
            check($sformatf("%s_valid[%0d]", tag, k), 32'(bus4.byte_valid), 32'd1);
            check($sformatf("%s_byte[%0d]", tag, k), 32'(bus4.byte_out), 32'(exp[k]));
            check($sformatf("%s_start[%0d]", tag, k), 32'(bus4.frame_start), 32'(k == 0));
            check($sformatf("%s_done[%0d]", tag, k), 32'(bus4.frame_done),
                  32'(k == exp.size() - 1));
            if (!bus4.pix_ready) low++;
            drive_noise4(noise);
            @(negedge clk);
        end
        bus4.pix_valid = 1'b0;
        check($sformatf("%s_valid_after", tag), 32'(bus4.byte_valid), 32'd0);
        check($sformatf("%s_byte_idle", tag), 32'(bus4.byte_out), 32'd0);
        check($sformatf("%s_ready_back", tag), 32'(bus4.pix_ready), 32'd1);
        check($sformatf("%s_ready_low_cycles", tag), 32'(low), 32'(3 * N4 + 1));
    endtask

    task automatic fill_random4(input int max_gap);
        for (int i = 0; i < N4; i++) send4(i == 0, 24'($urandom), max_gap);
    endtask

    // One 32x32 frame; starts filling at the current negedge, so consecutive calls run
    // frames back to back.
    task automatic run32(input int f);
        int w;
        int cnt;
        logic [7:0] e;
        for (int i = 0; i < N32; i++) px32[i] = 24'($urandom);
        check($sformatf("t6_ready_f%0d", f), 32'(bus32.pix_ready), 32'd1);
        for (int i = 0; i < N32; i++) begin
            bus32.pix_valid = 1'b1;
            bus32.pix_sof   = (i == 0);
            bus32.pix_rgb   = px32[i];
            @(negedge clk);
        end
        bus32.pix_valid = 1'b0;
        w = 0;
        while (!bus32.byte_valid && w < 8) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("t6_latency_f%0d", f), 32'(w), 32'd1);
        cnt = 0;
        while (bus32.byte_valid && cnt < 3 * N32 + 4) begin
            if (cnt < 3 * N32) begin
                e = 8'(px32[cnt % N32] >> (16 - 8 * (cnt / N32)));
                check($sformatf("t6_f%0d_byte[%0d]", f, cnt), 32'(bus32.byte_out), 32'(e));
                check($sformatf("t6_f%0d_start[%0d]", f, cnt), 32'(bus32.frame_start),
                      32'(cnt == 0));
                check($sformatf("t6_f%0d_done[%0d]", f, cnt), 32'(bus32.frame_done),
                      32'(cnt == 3 * N32 - 1));
            end
            cnt++;
            @(negedge clk);
        end
        check($sformatf("t6_valid_count_f%0d", f), 32'(cnt), 32'(3 * N32));
        check($sformatf("t6_ready_after_f%0d", f), 32'(bus32.pix_ready), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1_exp [$];
        logic [7:0] t5_exp [$];
        int         bv_cnt;

        for (int i = 0; i < N4; i++) begin
            vec[i].sof   = (i == 0);
            vec[i].rgb   = {8'(i), 8'(8'h40 + i), 8'(8'h80 + i)};
            vec[i].exp_r = 8'(i);
            vec[i].exp_g = 8'(8'h40 + i);
            vec[i].exp_b = 8'(8'h80 + i);
        end

        reset           = 1'b1;
        bus4.pix_valid  = 1'b0;
        bus4.pix_sof    = 1'b0;
        bus4.pix_rgb    = '0;
        bus32.pix_valid = 1'b0;
        bus32.pix_sof   = 1'b0;
        bus32.pix_rgb   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_ready", 32'(bus4.pix_ready), 32'd1);
        check("rst_byte_valid", 32'(bus4.byte_valid), 32'd0);
        check("rst_byte_out", 32'(bus4.byte_out), 32'd0);
        check("rst_frame_start", 32'(bus4.frame_start), 32'd0);
        check("rst_frame_done", 32'(bus4.frame_done), 32'd0);
        check("rst_frame_err", 32'(bus4.frame_err), 32'd0);
        check("rst_ready32", 32'(bus32.pix_ready), 32'd1);

        // Test 1: ramp pattern from the vector table.
        for (int i = 0; i < N4; i++) send4(vec[i].sof, vec[i].rgb, 0);
        for (int i = 0; i < N4; i++) t1_exp.push_back(vec[i].exp_r);
        for (int i = 0; i < N4; i++) t1_exp.push_back(vec[i].exp_g);
        for (int i = 0; i < N4; i++) t1_exp.push_back(vec[i].exp_b);
        exp_q.delete();
        drain4(t1_exp, 1'b0, "t1");

        // Test 2: same pixels with random valid gaps.
        for (int i = 0; i < N4; i++) send4(vec[i].sof, vec[i].rgb, 3);
        drain4(exp_q, 1'b0, "t2");
        exp_q.delete();

        // Test 3: valid held high with changing data during drain, then a clean frame.
        fill_random4(2);
        drain4(exp_q, 1'b1, "t3a");
        exp_q.delete();
        fill_random4(1);
        drain4(exp_q, 1'b0, "t3b");
        exp_q.delete();

        // Test 4: start-of-frame at pixel 5 restarts the frame and latches the error.
        for (int i = 0; i < 5; i++) send4(i == 0, 24'($urandom), 0);
        check("t4_err_before", 32'(bus4.frame_err), 32'd0);
        send4(1'b1, 24'($urandom), 0);
        check("t4_err_set", 32'(bus4.frame_err), 32'(m_err));
        for (int i = 1; i < N4; i++) send4(1'b0, 24'($urandom), 1);
        drain4(exp_q, 1'b0, "t4");
        exp_q.delete();
        check("t4_err_sticky", 32'(bus4.frame_err), 32'd1);

        // Test 5: reset during the fourth green drain cycle aborts the frame.
        fill_random4(0);
        t5_exp = exp_q;
        exp_q.delete();
        for (int j = 0; j < N4 + 3; j++) @(negedge clk);
        check("t5_byte_before_reset", 32'(bus4.byte_out), 32'(t5_exp[N4 + 2]));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("t5_valid_after_reset", 32'(bus4.byte_valid), 32'd0);
        check("t5_ready_after_reset", 32'(bus4.pix_ready), 32'd1);
        check("t5_byte_after_reset", 32'(bus4.byte_out), 32'd0);
        check("t5_err_cleared", 32'(bus4.frame_err), 32'd0);
        bv_cnt = 0;
        for (int j = 0; j < 6; j++) begin
            if (bus4.byte_valid) bv_cnt++;
            @(negedge clk);
        end
        check("t5_no_valid_after_abort", 32'(bv_cnt), 32'd0);
        fill_random4(1);
        drain4(exp_q, 1'b0, "t5");
        exp_q.delete();

        // Test 6: default 32x32, back-to-back frames.
        run32(0);
        run32(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/planar_rgb_serializer.md
PLANAR_RGB_SERIALIZER -- requirements
Module: planar_rgb_serializer

Interface
REQ-001 The block SHALL have parameter RES_X, default 32, frame width in pixels.
REQ-002 The block SHALL have parameter RES_Y, default 32, frame height in pixels; N = RES_X*RES_Y.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port pix_valid, input, 1 bit, upstream pixel valid.
REQ-006 The block SHALL have port pix_sof, input, 1 bit, start-of-frame marker, qualified by pix_valid.
REQ-007 The block SHALL have port pix_rgb, input, 24 bits, interleaved pixel {R[23:16], G[15:8], B[7:0]}, raster order.
REQ-008 The block SHALL have port pix_ready, output, 1 bit, block can accept a pixel.
REQ-009 The block SHALL have port byte_out, output, 8 bits, planar byte stream to the grayscale/filter stage.
REQ-010 The block SHALL have port byte_valid, output, 1 bit, byte_out carries stream data.
REQ-011 The block SHALL have port frame_start, output, 1 bit, one-cycle pulse with the first R byte.
REQ-012 The block SHALL have port frame_done, output, 1 bit, one-cycle pulse with the last B byte.
REQ-013 The block SHALL have port frame_err, output, 1 bit, sticky framing error flag.

Function
REQ-014 The block SHALL store R, G and B in three N-entry 8-bit planes, addressed by raster index row*RES_X+col.
REQ-015 The block SHALL implement states FILL, DRAIN_R, DRAIN_G, DRAIN_B.
REQ-016 In FILL, pix_ready SHALL be 1; a pixel is accepted when pix_valid && pix_ready at a rising edge.
REQ-017 An accepted pixel SHALL be written at the current write index, which then increments by 1.
REQ-018 An accepted pixel with pix_sof=1 SHALL be written at index 0, and the write index becomes 1.
REQ-019 If pix_sof=1 is accepted while the write index is non-zero, frame_err SHALL set to 1 and stay 1 until reset; the partial frame is discarded.
REQ-020 Accepting the pixel at index N-1 SHALL move the state to DRAIN_R on that edge, reset the read index to 0, and drive pix_ready low from the next cycle.
REQ-021 In DRAIN_x states, the read index SHALL advance by one every cycle with no stall; at N-1 it wraps to 0 and the state goes DRAIN_R->DRAIN_G->DRAIN_B->FILL.
REQ-022 byte_out and byte_valid SHALL be registered, one cycle after the read address.
REQ-023 The first byte_valid=1 cycle SHALL be 2 cycles after the edge that accepted pixel N-1.
REQ-024 byte_valid SHALL be 1 for exactly 3*N consecutive cycles per frame: N R bytes, then N G bytes, then N B bytes, each plane in raster order, with no gaps between planes.
REQ-025 byte_out SHALL be 0 whenever byte_valid=0.
REQ-026 frame_start SHALL be 1 only in the first byte_valid cycle, and frame_done only in the last byte_valid cycle.
REQ-027 pix_ready SHALL return to 1 in the cycle after the last B byte is presented, with the write index at 0.
REQ-028 pix_valid SHALL be ignored while pix_ready=0; no plane write occurs.
REQ-029 Index counters SHALL be ceil(log2(N))+1 bits wide; no arithmetic wraps except at N-1.

Reset
REQ-030 When reset=1 at an edge, the state SHALL become FILL, both indices 0, pix_ready=1, and byte_out, byte_valid, frame_start, frame_done and frame_err all 0.
REQ-031 Reset asserted mid-FILL or mid-DRAIN SHALL abort the frame immediately, with no further byte_valid; plane contents are don't-care.
REQ-032 Plane memories SHALL NOT require reset.

Verification
REQ-033 Test 1: RES_X=RES_Y=4; stream 16 pixels with pix_rgb={i, 8'h40+i, 8'h80+i}, first with sof -> after 2 cycles, 48 contiguous bytes 00..0F, 40..4F, 80..8F; frame_start on byte 0; frame_done on byte 47.
REQ-034 Test 2: Same as Test 1 with pix_valid toggling randomly during FILL -> identical 48-byte output; pix_ready=0 for exactly 49 cycles from the edge after the last accept.
REQ-035 Test 3: pix_valid held 1 during drain with changing data -> output unchanged; no data corruption; the next frame fills correctly.
REQ-036 Test 4: sof at pixel 5 of a frame -> frame_err=1; the frame restarts at index 0; the following 16 pixels produce a correct 48-byte output.
REQ-037 Test 5: reset asserted in DRAIN_G cycle 3 -> next cycle byte_valid=0 and pix_ready=1; a new full frame serializes correctly.
REQ-038 Test 6: default 32x32 with back-to-back frames -> exactly 3072 valid bytes per frame; byte 1023=R[1023], byte 1024=G[0], byte 2048=B[0].
